// File: rtl/uart_rx.sv
// uart_rx: receiver for the 6-bit tester UART link.
// Frame on the line: start(0), pad1(0), pad0(0), d5..d0 (MSB first), stop(1).
// The payload is presented on out_data together with a one-cycle out_valid strobe.
// Malformed frames produce a one-cycle out_frame_err strobe instead.
// Handshake: there is no back-pressure. out_valid and out_frame_err are
// single-cycle, mutually exclusive strobes. out_data is stable from the
// out_valid cycle until the next good frame.
// out_state exposes the FSM state for debug and checker binding.
module uart_rx #(
   parameter int CLKS_PER_BIT = 244,
   parameter int CNT_SIZE     = 8
) (
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic       in_rx,
   output logic [5:0] out_data,
   output logic       out_valid,
   output logic       out_frame_err,
   output logic       out_busy,
   output logic [2:0] out_state
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_BREAK = 3'd5;

   // Terminal counts: the start bit is sampled at its midpoint.
   // Every later bit is sampled one full bit period after the previous sample.
   localparam logic [CNT_SIZE-1:0] HALF_LAST = CNT_SIZE'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_SIZE-1:0] BIT_LAST  = CNT_SIZE'(CLKS_PER_BIT - 1);
   localparam logic [CNT_SIZE-1:0] CNT_ONE   = CNT_SIZE'(1);

   logic [1:0]          sync_q;
   logic                rx_s;
   logic [2:0]          state;
   logic [CNT_SIZE-1:0] tick_cnt;
   logic [2:0]          bit_idx;
   logic [7:0]          shift_q;
   logic                stop_bit;

   assign rx_s      = sync_q[1];
   assign out_state = state;

   // Two-flop synchronizer for the asynchronous serial line, idling high.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], in_rx};
      end
   end

   // Frame FSM: bit timing, sampling, frame check and output strobes.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state         <= ST_IDLE;
         tick_cnt      <= '0;
         bit_idx       <= '0;
         shift_q       <= '0;
         stop_bit      <= 1'b0;
         out_data      <= '0;
         out_valid     <= 1'b0;
         out_frame_err <= 1'b0;
         out_busy      <= 1'b0;
      end else begin
         out_valid     <= 1'b0;
         out_frame_err <= 1'b0;
         // Busy is registered from the current state.
         // It therefore drops in the same cycle as the DONE strobe.
         out_busy      <= (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state    <= ST_START;
                  tick_cnt <= '0;
               end
            end
            ST_START: begin
               if (tick_cnt == HALF_LAST) begin
                  if (rx_s) begin
                     // The line went high again before mid start bit.
                     // Treat this as a glitch and drop it silently.
                     state <= ST_IDLE;
                  end else begin
                     tick_cnt <= '0;
                     bit_idx  <= '0;
                     state    <= ST_DATA;
                  end
               end else begin
                  tick_cnt <= tick_cnt + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (tick_cnt == BIT_LAST) begin
                  shift_q  <= {shift_q[6:0], rx_s};
                  tick_cnt <= '0;
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end
               end else begin
                  tick_cnt <= tick_cnt + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (tick_cnt == BIT_LAST) begin
                  stop_bit <= rx_s;
                  tick_cnt <= '0;
                  state    <= ST_DONE;
               end else begin
                  tick_cnt <= tick_cnt + CNT_ONE;
               end
            end
            ST_DONE: begin
               // shift_q holds {pad1, pad0, d5..d0}.
               if (stop_bit && (shift_q[7:6] == 2'b00)) begin
                  out_data  <= shift_q[5:0];
                  out_valid <= 1'b1;
               end else begin
                  out_frame_err <= 1'b1;
               end
               state <= stop_bit ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
               // A line held low must not look like a new start bit.
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a frame-level reference model.
module tb_uart_rx;

   localparam int C    = 16;
   localparam int HALF = C / 2;
   // Strobe cycle relative to T0: 3 + HALF + 9*C.
   localparam int LAT  = 3 + HALF + 9 * C;

   logic       in_clk = 1'b0;
   logic       in_rst = 1'b1;
   logic       in_rx  = 1'b1;
   logic [5:0] out_data;
   logic       out_valid;
   logic       out_frame_err;
   logic       out_busy;
   logic [2:0] out_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Expected strobe entries: {cycle[31:0], kind{err,valid}[1:0], out_data[5:0]}.
   logic [39:0] exp_q[$];
   int          v_times[$];
   logic [5:0]  model_data = 6'h00;

   uart_rx #(.CLKS_PER_BIT(C), .CNT_SIZE(5)) dut (
      .in_clk(in_clk),
      .in_rst(in_rst),
      .in_rx(in_rx),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_frame_err(out_frame_err),
      .out_busy(out_busy),
      .out_state(out_state)
   );

   // Clock and cycle stamp.
   always #5 in_clk = ~in_clk;
   always @(posedge in_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [9:0] make_frame(input logic pad1, input logic pad0,
                                             input logic [5:0] d, input logic stop);
      return {1'b0, pad1, pad0, d, stop};
   endfunction

   // Scoreboard: every strobe must match the head of the expected queue.
   always @(negedge in_clk) begin
      if (!in_rst && (out_valid || out_frame_err)) begin
         logic [39:0] e;
         check("strobe_exclusive", 40'(out_valid & out_frame_err), 40'd0);
         check("busy_at_strobe", 40'(out_busy), 40'd0);
         check("strobe_expected", 40'(exp_q.size() != 0), 40'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("strobe_cycle", 40'(cyc), 40'(e[39:8]));
            check("strobe_kind", 40'({out_frame_err, out_valid}), 40'(e[7:6]));
            check("strobe_data", 40'(out_data), 40'(e[5:0]));
         end
         if (out_valid) v_times.push_back(cyc);
      end
   end

   // Driver: call at a negedge. bits[9] goes on the line first.
   // A reset is pulsed mid-bit at bit position rst_at (-1 means none).
   task automatic send_frame(input logic [9:0] bits, input int rst_at);
      int  t0;
      logic good;
      t0   = cyc + 1;
      good = bits[0] && (bits[8:7] == 2'b00);
      if (rst_at < 0) begin
         exp_q.push_back({32'(t0 + LAT), good ? 2'b01 : 2'b10, good ? bits[6:1] : model_data});
         if (good) model_data = bits[6:1];
      end
      for (int b = 0; b < 10; b++) begin
         in_rx = bits[9 - b];
         for (int c = 0; c < C; c++) begin
            @(negedge in_clk);
            if (b == 0 && c == 2) check("busy_before_t0p3", 40'(out_busy), 40'd0);
            if (b == 0 && c == 3) check("busy_at_t0p3", 40'(out_busy), 40'd1);
            if (b == rst_at && c == HALF) begin
               in_rst = 1'b1;
               #1;
               check("rst_data", 40'(out_data), 40'd0);
               check("rst_valid", 40'(out_valid), 40'd0);
               check("rst_err", 40'(out_frame_err), 40'd0);
               check("rst_busy", 40'(out_busy), 40'd0);
               model_data = 6'h00;
               repeat (3) @(negedge in_clk);
               in_rx  = 1'b1;
               in_rst = 1'b0;
               return;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      in_rx = 1'b1;
      repeat (n) @(negedge in_clk);
   endtask

   initial begin
      int t0;
      int idx;
      logic [5:0] d;
      int r;
      int g;

      // Reset state.
      repeat (3) @(negedge in_clk);
      check("reset_data", 40'(out_data), 40'd0);
      check("reset_valid", 40'(out_valid), 40'd0);
      check("reset_err", 40'(out_frame_err), 40'd0);
      check("reset_busy", 40'(out_busy), 40'd0);
      in_rst = 1'b0;
      idle(5);

      // Single good frame.
      send_frame(make_frame(1'b0, 1'b0, 6'h2D, 1'b1), -1);
      check("single_data", 40'(out_data), 40'h2D);
      idle(7);

      // Back-to-back frames with no idle gap.
      idx = v_times.size();
      send_frame(make_frame(1'b0, 1'b0, 6'h3F, 1'b1), -1);
      send_frame(make_frame(1'b0, 1'b0, 6'h00, 1'b1), -1);
      check("b2b_data", 40'(out_data), 40'h00);
      check("b2b_count", 40'(v_times.size() - idx), 40'd2);
      if (v_times.size() - idx == 2) check("b2b_spacing", 40'(v_times[idx + 1] - v_times[idx]), 40'd160);
      idle(10);

      // Five-cycle low glitch.
      t0 = cyc + 1;
      in_rx = 1'b0;
      repeat (5) @(negedge in_clk);
      in_rx = 1'b1;
      while (cyc < t0 + 11) @(negedge in_clk);
      check("glitch_busy", 40'(out_busy), 40'd0);
      idle(10);
      check("glitch_data", 40'(out_data), 40'h00);

      // Stop bit 0, then the line stays low for 50 more cycles.
      send_frame(make_frame(1'b0, 1'b0, 6'h12, 1'b0), -1);
      repeat (50) @(negedge in_clk);
      check("break_busy_low", 40'(out_busy), 40'd0);
      check("break_data", 40'(out_data), 40'h00);
      idle(30);
      check("break_busy_released", 40'(out_busy), 40'd0);

      // pad1 set: the frame is rejected and the data is kept.
      send_frame(make_frame(1'b0, 1'b0, 6'h0B, 1'b1), -1);
      idle(3);
      send_frame(make_frame(1'b1, 1'b0, 6'h15, 1'b1), -1);
      check("pad1_data", 40'(out_data), 40'h0B);
      idle(5);

      // Reset during a data bit, then a clean frame.
      send_frame(make_frame(1'b0, 1'b0, 6'h33, 1'b1), 5);
      idle(5);
      check("post_rst_data", 40'(out_data), 40'h00);
      send_frame(make_frame(1'b0, 1'b0, 6'h2A, 1'b1), -1);
      check("post_rst_frame", 40'(out_data), 40'h2A);

      // Randomized frames with occasional defects and random gaps.
      for (int i = 0; i < 24; i++) begin
         d = 6'($urandom_range(0, 63));
         r = $urandom_range(0, 9);
         g = $urandom_range(0, 12);
         send_frame(make_frame(r == 0, r == 1, d, r != 2), -1);
         if (r == 2 && g < 4) g = 4;
         idle(g);
         check("rand_data", 40'(out_data), 40'(model_data));
      end

      idle(40);
      check("all_strobes_seen", 40'(exp_q.size()), 40'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 6-bit tester UART link: it is the far-end decoder for the link's transmitter. It recovers each frame from the asynchronous `in_rx` line and presents the 6-bit payload with a one-cycle valid strobe. It also flags malformed frames. It sits on the host-to-tester path beside the transmitter and shares its clock and bit-period parameter.

## Interface
- `CLKS_PER_BIT`, default 244: clock cycles per serial bit. Must equal the transmitter's per-bit period, TICKS_PER_BIT + 1.
- `CNT_SIZE`, default 8: tick-counter width. Must satisfy 2^CNT_SIZE > CLKS_PER_BIT.
- `in_clk`, input, 1: system clock. Everything is clocked on its rising edge.
- `in_rst`, input, 1: reset. Asynchronous, active-high.
- `in_rx`, input, 1: serial line. Idle high; asynchronous to `in_clk`.
- `out_data`, output, 6: last good payload. Holds until the next good frame.
- `out_valid`, output, 1: one-cycle pulse when `out_data` has just been updated.
- `out_frame_err`, output, 1: one-cycle pulse when a frame is rejected.
- `out_busy`, output, 1: high while a frame is being received (states START through STOP).

## Operation
- Frame on the line, in time order, 10 bits:
  - start = 0
  - pad1 = 0, pad0 = 0
  - d5, d4, d3, d2, d1, d0 (MSB first)
  - stop = 1
- `in_rx` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized signal `rx_s`.
- States and transitions:
  - IDLE → START when `rx_s` = 0. The tick counter clears.
  - START: count HALF = CLKS_PER_BIT/2 (integer division) cycles, then sample. If the sample is 1 (glitch), go to IDLE silently. If 0, clear the tick counter and the bit index, then go to DATA.
  - DATA: each time the tick counter reaches CLKS_PER_BIT-1, sample `rx_s` into a shift register (MSB first), wrap the counter and advance the bit index. After the 8th sample (index 7), go to STOP.
  - STOP: sample after a further CLKS_PER_BIT cycles. Go to DONE.
  - DONE (1 cycle): evaluate the frame, then go to IDLE, or to BREAK if the stop sample was 0.
  - BREAK: wait until `rx_s` = 1, then go to IDLE. This prevents a stuck-low line from re-triggering.
- Frame check in DONE:
  - Good frame (stop = 1 and both pad bits = 0): `out_data` ← bits d5..d0 and `out_valid` = 1.
  - Otherwise: `out_frame_err` = 1 and `out_data` is unchanged.
- `out_valid` and `out_frame_err` are never high in the same cycle.
- Receiving stops at mid-stop-bit, so a start bit that immediately follows the stop bit is detected normally.
- Counters wrap to 0. No arithmetic overflow is possible when CNT_SIZE is legal.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `out_frame_err` = 0, `out_busy` = 0, state = IDLE, synchronizer = 1.
- Reset asserted mid-frame: on the next evaluation all outputs and state take their reset values. The partial frame is discarded with no pulse.
- Let T0 be the first clock edge at which the first synchronizer flop captures 0.
  - `rx_s` falls at T0+1, and START is entered at T0+2.
  - Start sample at T0+2+HALF.
  - Data sample k (k = 0..7) at T0+2+HALF+(k+1)·CLKS_PER_BIT.
  - Stop sample at T0+2+HALF+9·CLKS_PER_BIT.
  - `out_valid` / `out_frame_err` high for exactly the one cycle at T0+3+HALF+9·CLKS_PER_BIT.
- `out_busy` rises at T0+3 and falls in the same cycle that the valid or error pulse is asserted.
- Back-to-back frames at the transmitter's maximum rate are accepted without loss.

## Test plan
- CLKS_PER_BIT = 16. Send payload 6'h2D as a correctly framed sequence. Required: `out_valid` pulses once at T0+3+8+144, `out_data` = 6'h2D, `out_frame_err` stays 0.
- Two back-to-back frames, 6'h3F then 6'h00, with no idle gap. Required: two `out_valid` pulses exactly 160 cycles apart, and `out_data` ends at 6'h00.
- A 5-cycle low glitch on an idle line. Required: return to IDLE with `out_busy` low within 11 cycles, and no valid or error pulse.
- Stop bit forced to 0, line held low 50 extra cycles, then released. Required: one `out_frame_err` pulse, `out_data` unchanged, and no new frame starts until the line returns high.
- pad1 = 1 with payload 6'h15. Required: `out_frame_err` pulse and `out_data` retains its previous value.
- `in_rst` asserted during data bit 4 and released 3 cycles later, followed by a clean frame carrying 6'h2A. Required: all outputs reset, no pulse from the partial frame, then `out_data` = 6'h2A with `out_valid` pulsing.
